// File: rtl/ex_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// ex_muldiv_pkg
//   Shared encodings for the EX-stage multiply/divide unit:
//   - muldiv op codes (RISC-V funct3 of the M extension), MD_MUL..MD_REMU
//   - FSM state encodings MD_IDLE, MD_CALC, MD_FIX, MD_DONE
//   - MD_XLEN, the default operand width
//   - small decode helpers for operand signedness
// ---------------------------------------------------------------------------
package ex_muldiv_pkg;

    localparam int MD_XLEN = 32;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_CALC = 2'd1;
    localparam logic [1:0] MD_FIX  = 2'd2;
    localparam logic [1:0] MD_DONE = 2'd3;

    // funct3[2] separates the divide/remainder group from the multiplies.
    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // rs1 is treated as two's complement for MULH, MULHSU, DIV and REM.
    function automatic logic md_op1_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is treated as two's complement for MULH, DIV and REM.
    function automatic logic md_op2_signed(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/ex_div_iter.sv
// ---------------------------------------------------------------------------
// ex_div_iter
//   One combinational step of an unsigned restoring divider.
//   The partial remainder is shifted left by one, taking in the next dividend
//   bit from the top of the quotient register; the divisor is subtracted when
//   it fits and the matching quotient bit is shifted in at the bottom.
// Ports
//   rem_in   in   XLEN  partial remainder before this step
//   quo_in   in   XLEN  dividend bits still to consume / quotient bits so far
//   divisor  in   XLEN  divisor magnitude
//   rem_out  out  XLEN  partial remainder after this step
//   quo_out  out  XLEN  quotient register after this step
// ---------------------------------------------------------------------------
module ex_div_iter #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        // rem_in < divisor, so diff[XLEN] is a clean borrow flag:
        // set exactly when the divisor does not fit.
        if (diff[XLEN]) begin
            rem_out = shifted[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end else begin
            rem_out = diff[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv
//   Multi-cycle RV32M/RV64M multiply/divide unit beside the EX-stage ALU.
//   Operands are converted to magnitudes on acceptance, processed with a
//   radix-2 shift-add multiplier or restoring divider (one step per cycle),
//   then sign-corrected. Divide-by-zero and signed overflow finish directly.
//   FSM: IDLE -> CALC -> FIX -> DONE -> IDLE (special cases IDLE -> DONE).
// Configuration
//   MULDIV_FAST_MUL_EN  when defined, multiplies use a single-cycle array
//                       multiply and go IDLE -> FIX -> DONE; divides unchanged.
// Ports
//   clk      in   1     core clock, rising edge
//   rst      in   1     asynchronous reset, active-high
//   start    in   1     M-op present in EX; sampled only in IDLE
//   op       in   3     funct3 (MD_MUL..MD_REMU)
//   op1      in   XLEN  rs1 value
//   op2      in   XLEN  rs2 value
//   flush    in   1     pipeline flush; aborts the current op
//   stall_o  out  1     hold IF/ID/EX (combinational)
//   done     out  1     result valid this cycle, one-cycle pulse
//   result   out  XLEN  result, held until the next accepted op completes
// ---------------------------------------------------------------------------
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            stall_o,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    logic [1:0]        state;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q;       // |op1| (multiplicand / dividend)
    logic [XLEN-1:0]   b_q;       // |op2| (multiplier / divisor)
    logic              neg_q;     // final result must be negated
    logic [2*XLEN-1:0] acc;       // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [CNT_W-1:0]  cnt;

    logic              accept;
    logic              sign1, sign2;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_val;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN-1:0]   rem_next, quo_next;

    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_mag, div_fix;
    logic [XLEN-1:0]   fix_val;
    logic [1:0]        mul_entry;

`ifdef MULDIV_FAST_MUL_EN
    // Array multiply of the latched magnitudes; multiplies skip CALC.
    assign prod_mag  = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
    assign mul_entry = MD_FIX;
`else
    assign prod_mag  = acc;
    assign mul_entry = MD_CALC;
`endif

    assign accept  = (state == MD_IDLE) && start && !flush;
    assign stall_o = !flush && (((state == MD_IDLE) && start) || (state == MD_CALC) || (state == MD_FIX));
    assign done    = (state == MD_DONE) && !flush;

    // Acceptance-time decode: magnitudes, result sign and the special cases
    // that bypass the iterative datapath.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (defaults first), otherwise synthesis infers latches.
        special_val = '0;

        sign1    = md_op1_signed(op) && op1[XLEN-1];
        sign2    = md_op2_signed(op) && op2[XLEN-1];
        a_mag    = sign1 ? -op1 : op1;
        b_mag    = sign2 ? -op2 : op2;
        div_zero = md_is_div(op) && (op2 == '0);
        div_ovf  = ((op == MD_DIV) || (op == MD_REM)) &&
                   (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
        special  = div_zero || div_ovf;

        case (op)
            MD_DIV, MD_DIVU: special_val = div_zero ? '1 : op1;
            MD_REM, MD_REMU: special_val = div_zero ? op1 : '0;
            default:         special_val = '0;
        endcase
    end

    // One shift-add multiply step: add the multiplicand when the current
    // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
    end

    ex_div_iter #(
        .XLEN (XLEN)
    ) u_div_iter (
        .rem_in  (acc[2*XLEN-1:XLEN]),
        .quo_in  (acc[XLEN-1:0]),
        .divisor (b_q),
        .rem_out (rem_next),
        .quo_out (quo_next)
    );

    // Sign correction and result selection.
    always_comb begin
        fix_val  = '0;
        prod_fix = neg_q ? -prod_mag : prod_mag;
        div_mag  = ((op_q == MD_REM) || (op_q == MD_REMU)) ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        div_fix  = neg_q ? -div_mag : div_mag;

        case (op_q)
            MD_MUL:                       fix_val = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU,
            MD_REM, MD_REMU:              fix_val = div_fix;
            default:                      fix_val = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every register is reset here, datapath included, so the unit
        // is fully deterministic after reset and the outputs read zero.
        if (rst) begin
            state  <= MD_IDLE;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            neg_q  <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (flush) begin
            // Abort: back to IDLE, result untouched.
            state <= MD_IDLE;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (accept) begin
                        op_q  <= op;
                        cnt   <= '0;
                        a_q   <= a_mag;
                        b_q   <= b_mag;
                        // REM takes the dividend's sign; all others the sign product.
                        neg_q <= (op == MD_REM) ? sign1 : (sign1 ^ sign2);
                        acc   <= md_is_div(op) ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
                        if (special) begin
                            result <= special_val;
                            state  <= MD_DONE;
                        end else if (md_is_div(op)) begin
                            state  <= MD_CALC;
                        end else begin
                            state  <= mul_entry;
                        end
                    end
                end
                MD_CALC: begin
                    acc <= md_is_div(op_q) ? {rem_next, quo_next} : mul_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        state <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    result <= fix_val;
                    state  <= MD_DONE;
                end
                default: begin
                    state <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv
//   Self-checking bench for ex_muldiv (XLEN=32). Directed cases, flush and
//   reset scenarios, then randomized ops compared with an arithmetic model.
//   Compile with +define+MULDIV_FAST_MUL_EN to exercise the fast-multiply build.
// ---------------------------------------------------------------------------
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int XLEN     = 32;
    localparam int LAT_ITER = XLEN + 2;
`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT_MUL  = 2;
`else
    localparam int LAT_MUL  = XLEN + 2;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            flush;
    logic            stall_o;
    logic            done;
    logic [XLEN-1:0] result;

    int              n_cmp = 0;
    int              n_bad = 0;
    logic [XLEN-1:0] last_exp;

    ex_muldiv #(
        .XLEN (XLEN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .op1     (op1),
        .op2     (op2),
        .flush   (flush),
        .stall_o (stall_o),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics in plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            MD_MUL:    begin up = ua * ub;          return up[31:0];  end
            MD_MULH:   begin sp = sa * sb;          return sp[63:32]; end
            MD_MULHSU: begin sp = sa * longint'(ub); return sp[63:32]; end
            MD_MULHU:  begin up = ua * ub;          return up[63:32]; end
            MD_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return a;
                sp = sa / sb;
                return sp[31:0];
            end
            MD_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                up = ua / ub;
                return up[31:0];
            end
            MD_REM: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                sp = sa % sb;
                return sp[31:0];
            end
            default: begin
                if (b == 0) return a;
                up = ua % ub;
                return up[31:0];
            end
        endcase
    endfunction

    // Cycles from acceptance (cycle 0) to the done pulse.
    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && ((b == 0) ||
            (((o == MD_DIV) || (o == MD_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))))
            return 1;
        if (!o[2]) return LAT_MUL;
        return LAT_ITER;
    endfunction

    // Issue one op (caller is just after a clock edge, unit idle), follow it
    // to done, check result, latency, stall profile and the single done pulse.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit hold, input string tag);
        int lat;
        int got_lat;
        bit stall_bad;
        lat     = exp_latency(o, a, b);
        got_lat = 999;
        start   = 1'b1;
        op      = o;
        op1     = a;
        op2     = b;
        #1;
        stall_bad = (stall_o !== 1'b1);
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (!hold) start = 1'b0;
            #1;
            if (done === 1'b1) begin
                got_lat = c;
                if (stall_o !== 1'b0) stall_bad = 1'b1;
                break;
            end
            if (stall_o !== 1'b1) stall_bad = 1'b1;
        end
        check({tag, "_result"}, result, exp);
        check({tag, "_latency"}, got_lat, lat);
        check({tag, "_stall"}, stall_bad, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        #1;
        check({tag, "_one_done"}, done, 1'b0);
        last_exp = exp;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [5];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        op       = '0;
        op1      = '0;
        op2      = '0;
        last_exp = '0;

        #12;
        check("reset_done",   done,    1'b0);
        check("reset_result", result,  32'h0);
        check("reset_stall",  stall_o, 1'b0);
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed values
        run_op(MD_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7_m3");
        run_op(MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulh_min");
        run_op(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu_max");
        run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, "mulhsu_m1_2");
        run_op(MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "div_m7_2");
        run_op(MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, "rem_m7_2");
        run_op(MD_DIVU,   32'd100,       32'd7,         32'd14,        1'b0, "divu_100_7");
        run_op(MD_REMU,   32'd100,       32'd7,         32'd2,         1'b0, "remu_100_7");
        run_op(MD_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, "div_by0");
        run_op(MD_REM,    32'd5,         32'd0,         32'd5,         1'b0, "rem_by0");
        run_op(MD_DIVU,   32'd9,         32'd0,         32'hFFFF_FFFF, 1'b0, "divu_by0");
        run_op(MD_REMU,   32'd9,         32'd0,         32'd9,         1'b0, "remu_by0");
        run_op(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "div_ovf");
        run_op(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b0, "rem_ovf");

        // Start held high through DONE: one done per instruction
        run_op(MD_MUL,    32'd1234,      32'd5678,      32'd7006652,   1'b1, "hold_mul");
        run_op(MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b1, "hold_div");
        run_op(MD_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, "hold_special");

        // Flush in CALC cycle 10
        start = 1'b1;
        op    = MD_DIVU;
        op1   = 32'd1000;
        op2   = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        #1;
        check("flush_stall", stall_o, 1'b0);
        check("flush_done",  done,    1'b0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        check("flush_idle_stall", stall_o, 1'b0);
        check("flush_idle_done",  done,    1'b0);
        check("flush_result",     result,  last_exp);
        run_op(MD_REMU, 32'd1000, 32'd3, 32'd1, 1'b0, "after_flush");

        // Flush and start together in IDLE: not accepted
        start = 1'b1;
        flush = 1'b1;
        op    = MD_DIVU;
        op1   = 32'd50;
        op2   = 32'd5;
        #1;
        check("fs_stall", stall_o, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        #1;
        check("fs_not_accepted", stall_o, 1'b0);
        check("fs_result",       result,  last_exp);

        // Reset in CALC: outputs clear asynchronously
        start = 1'b1;
        op    = MD_MUL;
        op1   = 32'd5;
        op2   = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("rst_calc_done",   done,    1'b0);
        check("rst_calc_result", result,  32'h0);
        check("rst_calc_stall",  stall_o, 1'b0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, model(MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0),
               1'b0, "after_rst");

        // Randomized ops against the model
        for (int i = 0; i < 150; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            run_op(ro, ra, rb, model(ro, ra, rb), ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
